// File: rtl/imm_ext_pipe.sv
// Pipelined immediate generator: six extension modes behind a valid/ready
// handshake with a two-entry (main + skid) output buffer.
module imm_ext_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 16,
    parameter int JMP_WIDTH  = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [JMP_WIDTH-1:0]  instr,
    input  logic [2:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] imm_out,
    output logic                  mode_err
);

    localparam logic [2:0] MODE_SEXT   = 3'd0;
    localparam logic [2:0] MODE_ZEXT   = 3'd1;
    localparam logic [2:0] MODE_UPPER  = 3'd2;
    localparam logic [2:0] MODE_BRANCH = 3'd3;
    localparam logic [2:0] MODE_JUMP   = 3'd4;
    localparam logic [2:0] MODE_SHAMT  = 3'd5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    buf_state_t              state_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   m_data_r;
    logic                    m_err_r;
    logic [DATA_WIDTH-1:0]   s_data_r;
    logic                    s_err_r;

    logic [DATA_WIDTH-1:0]   ext_data_s;
    logic                    ext_err_s;
    logic                    accept_s;
    logic                    retire_s;

    function automatic logic [DATA_WIDTH-1:0] sign_ext(input logic [IMM_WIDTH-1:0] imm);
        logic [DATA_WIDTH-1:0] r;
        r = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zero_ext(input logic [IMM_WIDTH-1:0] imm);
        logic [DATA_WIDTH-1:0] r;
        r = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm};
        return r;
    endfunction

    // Extension function; reserved modes produce zero with the error flag.
    always_comb begin
        logic [DATA_WIDTH-1:0] sext_v;
        ext_data_s = '0;
        ext_err_s  = 1'b0;
        sext_v     = sign_ext(instr[IMM_WIDTH-1:0]);
        case (mode)
            MODE_SEXT:   ext_data_s = sext_v;
            MODE_ZEXT:   ext_data_s = zero_ext(instr[IMM_WIDTH-1:0]);
            MODE_UPPER:  ext_data_s[DATA_WIDTH-1 -: IMM_WIDTH] = instr[IMM_WIDTH-1:0];
            MODE_BRANCH: ext_data_s = {sext_v[DATA_WIDTH-3:0], 2'b00};
            MODE_JUMP:   ext_data_s[JMP_WIDTH+1:2] = instr;
            MODE_SHAMT:  ext_data_s[4:0] = instr[10:6];
            default: begin
                ext_data_s = '0;
                ext_err_s  = 1'b1;
            end
        endcase
    end

    assign accept_s = in_valid & in_ready_r;
    assign retire_s = out_valid_r & out_ready;

    // Buffer FSM; only accepted data is ever captured, so idle X inputs stay out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            m_data_r    <= '0;
            m_err_r     <= 1'b0;
            s_data_r    <= '0;
            s_err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        m_data_r    <= ext_data_s;
                        m_err_r     <= ext_err_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_ONE;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                ST_ONE: begin
                    if (accept_s && retire_s) begin
                        m_data_r <= ext_data_s;
                        m_err_r  <= ext_err_s;
                    end else if (accept_s) begin
                        s_data_r   <= ext_data_s;
                        s_err_r    <= ext_err_s;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_FULL;
                    end else if (retire_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_EMPTY;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (retire_s) begin
                        m_data_r   <= s_data_r;
                        m_err_r    <= s_err_r;
                        in_ready_r <= 1'b1;
                        state_r    <= ST_ONE;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign imm_out   = m_data_r;
    assign mode_err  = m_err_r;

endmodule
